// File: rtl/sd_burst_interface.sv
// SD burst interface: CPU register window plus 512-byte sector buffer that
// sequences multi-sector reads/writes through an external sector engine.
module sd_burst_interface #(
    parameter int WIN_BITS = 7,
    parameter int CNT_W    = 8,
    parameter int TMO_W    = 20
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        R_W_n,
    input  logic [7:0]  reg_addr_i,
    input  logic [7:0]  data_i,
    input  logic        sd_cs,
    output logic [7:0]  data_o,
    output logic        irq_o,
    output logic        eng_rstart,
    output logic        eng_wstart,
    output logic [31:0] eng_sector,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic        eng_outen,
    input  logic [8:0]  eng_outaddr,
    input  logic [7:0]  eng_outbyte,
    output logic [7:0]  eng_inbyte
);

    localparam int PG_W = 9 - WIN_BITS;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        WAIT_ACK,
        ERROR
    } state_t;

    state_t             state;
    logic [31:0]        address;
    logic [CNT_W-1:0]   count;
    logic [PG_W-1:0]    page;
    logic [TMO_W-1:0]   tmo;
    logic               irq_en;
    logic               sector_ready;
    logic               done_flag;
    logic               error;
    logic               dir_read;
    logic [7:0]         sector_buf [0:511];

    logic               busy;
    logic               cpu_wr;
    logic               reg_wr;
    logic               win_wr;
    logic               wr_start;
    logic               wr_ack;
    logic               wr_abort;
    logic [8:0]         win_idx;

    assign cpu_wr   = sd_cs & ~R_W_n;
    assign reg_wr   = cpu_wr & ~reg_addr_i[7];
    assign win_wr   = cpu_wr & reg_addr_i[7];
    assign win_idx  = {page, reg_addr_i[WIN_BITS-1:0]};
    assign wr_start = reg_wr && ((reg_addr_i == 8'h05) || (reg_addr_i == 8'h06));
    assign wr_ack   = reg_wr && (reg_addr_i == 8'h0A);
    assign wr_abort = reg_wr && (reg_addr_i == 8'h0B);

    assign busy       = (state != IDLE);
    assign eng_sector = address;
    assign irq_o      = irq_en & (sector_ready | done_flag | error);
    assign eng_inbyte = sector_buf[eng_outaddr];

    // Engine write is ordered last so it wins a same-cycle collision.
    always_ff @(posedge clk_i) begin
        if (win_wr) begin
            sector_buf[win_idx] <= data_i;
        end
        if (eng_outen) begin
            sector_buf[eng_outaddr] <= eng_outbyte;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            address      <= '0;
            count        <= '0;
            page         <= '0;
            tmo          <= '0;
            irq_en       <= 1'b0;
            sector_ready <= 1'b0;
            done_flag    <= 1'b0;
            error        <= 1'b0;
            dir_read     <= 1'b0;
            eng_rstart   <= 1'b0;
            eng_wstart   <= 1'b0;
        end else begin
            eng_rstart <= 1'b0;
            eng_wstart <= 1'b0;

            if (reg_wr && (reg_addr_i == 8'h07)) begin
                page <= data_i[PG_W-1:0];
            end
            if (reg_wr && (reg_addr_i == 8'h09)) begin
                irq_en <= data_i[0];
            end

            // Abort outranks everything, including a coincident eng_done.
            if (wr_abort) begin
                state        <= IDLE;
                sector_ready <= 1'b0;
                done_flag    <= 1'b0;
                error        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (reg_wr) begin
                            case (reg_addr_i)
                                8'h00:   address[7:0]   <= data_i;
                                8'h01:   address[15:8]  <= data_i;
                                8'h02:   address[23:16] <= data_i;
                                8'h03:   address[31:24] <= data_i;
                                8'h08:   count          <= CNT_W'(data_i);
                                default: ;
                            endcase
                        end
                        if (wr_ack) begin
                            done_flag <= 1'b0;
                        end
                        if (wr_start && (count != '0)) begin
                            state        <= START;
                            dir_read     <= (reg_addr_i == 8'h05);
                            sector_ready <= 1'b0;
                            done_flag    <= 1'b0;
                            error        <= 1'b0;
                        end
                    end
                    START: begin
                        if (!eng_busy) begin
                            eng_rstart <= dir_read;
                            eng_wstart <= ~dir_read;
                            tmo        <= '0;
                            state      <= XFER;
                        end
                    end
                    XFER: begin
                        if (eng_done) begin
                            address <= address + 32'd1;
                            count   <= count - CNT_W'(1);
                            if (count == CNT_W'(1)) begin
                                state     <= IDLE;
                                done_flag <= 1'b1;
                            end else begin
                                state        <= WAIT_ACK;
                                sector_ready <= 1'b1;
                            end
                        end else if (tmo == '1) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    WAIT_ACK: begin
                        if (wr_ack) begin
                            sector_ready <= 1'b0;
                            state        <= START;
                        end
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (reg_addr_i[7]) begin
            data_o = sector_buf[win_idx];
        end else begin
            case (reg_addr_i)
                8'h00:   data_o = address[7:0];
                8'h01:   data_o = address[15:8];
                8'h02:   data_o = address[23:16];
                8'h03:   data_o = address[31:24];
                8'h04:   data_o = {4'b0000, irq_en, error, sector_ready, busy};
                8'h07:   data_o = 8'(page);
                8'h08:   data_o = 8'(count);
                8'h09:   data_o = {7'b0000000, irq_en};
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_burst_interface.sv
// Self-checking bench for sd_burst_interface: start pulses and buffer bytes are
// checked against scoreboard queues, register state inline per scenario.
module tb_sd_burst_interface;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        R_W_n;
    logic [7:0]  reg_addr_i;
    logic [7:0]  data_i;
    logic        sd_cs;
    logic [7:0]  data_o;
    logic        irq_o;
    logic        eng_rstart;
    logic        eng_wstart;
    logic [31:0] eng_sector;
    logic        eng_busy;
    logic        eng_done;
    logic        eng_outen;
    logic [8:0]  eng_outaddr;
    logic [7:0]  eng_outbyte;
    logic [7:0]  eng_inbyte;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [32:0] pulse_q[$];
    logic [7:0]  buf_q[$];
    logic [32:0] mon_exp;
    logic [32:0] mon_got;

    sd_burst_interface #(.WIN_BITS(7), .CNT_W(8), .TMO_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
        .data_i(data_i), .sd_cs(sd_cs), .data_o(data_o), .irq_o(irq_o),
        .eng_rstart(eng_rstart), .eng_wstart(eng_wstart), .eng_sector(eng_sector),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_outen(eng_outen),
        .eng_outaddr(eng_outaddr), .eng_outbyte(eng_outbyte), .eng_inbyte(eng_inbyte)
    );

    always #5 clk_i = ~clk_i;

    // Every start pulse must match the next expected {direction, sector}.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && (eng_rstart === 1'b1 || eng_wstart === 1'b1)) begin
            pulses++;
            total++;
            mon_got = {eng_rstart, eng_sector};
            if (pulse_q.size() == 0) begin
                bad++;
                $display("FAIL start_pulse: got unexpected rd=%0b wr=%0b sector=%h, required no pulse",
                         eng_rstart, eng_wstart, eng_sector);
            end else begin
                mon_exp = pulse_q.pop_front();
                if (mon_got !== mon_exp || (eng_rstart & eng_wstart) !== 1'b0) begin
                    bad++;
                    $display("FAIL start_pulse: got rd=%0b wr=%0b sector=%h, required rd=%0b sector=%h",
                             eng_rstart, eng_wstart, eng_sector, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_i);
        sd_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = a; data_i = d;
        @(negedge clk_i);
        sd_cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk_i);
        sd_cs = 1'b1; R_W_n = 1'b1; reg_addr_i = a;
        #1 d = data_o;
        sd_cs = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        cpu_write(8'h00, a[7:0]);
        cpu_write(8'h01, a[15:8]);
        cpu_write(8'h02, a[23:16]);
        cpu_write(8'h03, a[31:24]);
    endtask

    task automatic read_addr(output logic [31:0] a);
        logic [7:0] b;
        cpu_read(8'h00, b); a[7:0] = b;
        cpu_read(8'h01, b); a[15:8] = b;
        cpu_read(8'h02, b); a[23:16] = b;
        cpu_read(8'h03, b); a[31:24] = b;
    endtask

    task automatic pulse_done();
        @(negedge clk_i); eng_done = 1'b1;
        @(negedge clk_i); eng_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [31:0] a;
        rst_n_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        cpu_read(8'h04, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_status: got %h, required 00", v); end
        read_addr(a);
        total++; if (a !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h, required 0", a); end
        cpu_read(8'h08, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_count: got %h, required 00", v); end
        cpu_read(8'h07, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_page: got %h, required 00", v); end
        total++;
        if ({irq_o, eng_rstart, eng_wstart} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs: got irq/rs/ws=%b, required 000", {irq_o, eng_rstart, eng_wstart});
        end
    endtask

    task automatic test_single_read();
        logic [7:0] v;
        logic [31:0] a;
        int p;
        p = pulses;
        cpu_write(8'h09, 8'h01);
        set_addr(32'h0000_1000);
        cpu_write(8'h08, 8'h01);
        pulse_q.push_back({1'b1, 32'h0000_1000});
        cpu_write(8'h05, 8'h00);
        tick(3);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h09) begin bad++; $display("FAIL single_busy: got %h, required 09", v); end
        pulse_done();
        read_addr(a);
        total++; if (a !== 32'h0000_1001) begin bad++; $display("FAIL single_addr: got %h, required 00001001", a); end
        cpu_read(8'h08, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL single_count: got %h, required 00", v); end
        cpu_read(8'h04, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL single_status: got %h, required 08", v); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL single_irq_done: got %b, required 1", irq_o); end
        total++; if (pulses !== p + 1) begin bad++; $display("FAIL single_pulses: got %0d, required %0d", pulses - p, 1); end
        cpu_write(8'h0A, 8'h00);
        #1;
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL single_ack_idle: got irq %b, required 0", irq_o); end
    endtask

    task automatic test_burst_write();
        logic [7:0] v;
        logic [31:0] a;
        int p;
        set_addr(32'h0000_2000);
        cpu_write(8'h08, 8'h03);
        pulse_q.push_back({1'b0, 32'h0000_2000});
        cpu_write(8'h06, 8'h00);
        tick(3);
        pulse_done();
        cpu_read(8'h04, v);
        total++; if (v !== 8'h0B) begin bad++; $display("FAIL burst_wait0_status: got %h, required 0B", v); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL burst_wait0_irq: got %b, required 1", irq_o); end
        pulse_done();
        read_addr(a);
        total++; if (a !== 32'h0000_2001) begin bad++; $display("FAIL burst_stray_done: got addr %h, required 00002001", a); end
        eng_busy = 1'b1;
        p = pulses;
        pulse_q.push_back({1'b0, 32'h0000_2001});
        cpu_write(8'h0A, 8'h00);
        tick(4);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h09 || pulses !== p) begin bad++; $display("FAIL burst_engine_busy: got status %h pulses %0d, required 09 and 0", v, pulses - p); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL burst_ack_irq: got %b, required 0", irq_o); end
        eng_busy = 1'b0;
        tick(3);
        total++; if (pulses !== p + 1) begin bad++; $display("FAIL burst_after_busy: got %0d pulses, required 1", pulses - p); end
        pulse_done();
        cpu_read(8'h04, v);
        total++; if (v !== 8'h0B || irq_o !== 1'b1) begin bad++; $display("FAIL burst_wait1: got status %h irq %b, required 0B and 1", v, irq_o); end
        pulse_q.push_back({1'b0, 32'h0000_2002});
        cpu_write(8'h0A, 8'h00);
        tick(3);
        pulse_done();
        read_addr(a);
        total++; if (a !== 32'h0000_2003) begin bad++; $display("FAIL burst_end_addr: got %h, required 00002003", a); end
        cpu_read(8'h04, v);
        total++; if (v !== 8'h08 || irq_o !== 1'b1) begin bad++; $display("FAIL burst_end_status: got status %h irq %b, required 08 and 1", v, irq_o); end
        cpu_write(8'h0A, 8'h00);
        cpu_write(8'h09, 8'h00);
    endtask

    task automatic test_window();
        logic [7:0] v;
        cpu_write(8'h07, 8'h02);
        cpu_write(8'h85, 8'h5A);
        buf_q.push_back(8'h5A);
        buf_q.push_back(8'h5A);
        @(negedge clk_i); eng_outaddr = 9'h105;
        #1 v = buf_q.pop_front();
        total++; if (eng_inbyte !== v) begin bad++; $display("FAIL window_eng_read: got %h, required %h", eng_inbyte, v); end
        cpu_read(8'h85, v);
        total++; if (v !== buf_q.pop_front()) begin bad++; $display("FAIL window_cpu_read: got %h, required 5A", v); end
        @(negedge clk_i);
        eng_outen = 1'b1; eng_outaddr = 9'h0AB; eng_outbyte = 8'hC3;
        buf_q.push_back(8'hC3);
        @(negedge clk_i); eng_outen = 1'b0;
        cpu_write(8'h07, 8'h01);
        cpu_read(8'hAB, v);
        total++; if (v !== buf_q.pop_front()) begin bad++; $display("FAIL window_eng_write: got %h, required C3", v); end
        cpu_write(8'h07, 8'h03);
        cpu_write(8'hFF, 8'h77);
        buf_q.push_back(8'h77);
        @(negedge clk_i); eng_outaddr = 9'h1FF;
        #1 v = buf_q.pop_front();
        total++; if (eng_inbyte !== v) begin bad++; $display("FAIL window_top_byte: got %h, required %h", eng_inbyte, v); end
        cpu_read(8'h07, v);
        total++; if (v !== 8'h03) begin bad++; $display("FAIL window_page_rd: got %h, required 03", v); end
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        logic [31:0] a;
        int waited;
        set_addr(32'h0000_0010);
        cpu_write(8'h08, 8'h02);
        pulse_q.push_back({1'b1, 32'h0000_0010});
        cpu_write(8'h05, 8'h00);
        tick(10);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL timeout_early: got %h, required 01", v); end
        waited = 0;
        while (v !== 8'h05 && waited < 30) begin
            cpu_read(8'h04, v);
            waited++;
        end
        total++; if (v !== 8'h05) begin bad++; $display("FAIL timeout_error: got %h after %0d cycles, required 05", v, waited); end
        pulse_done();
        tick(3);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h05) begin bad++; $display("FAIL timeout_persist: got %h, required 05", v); end
        cpu_write(8'h0B, 8'h00);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL timeout_abort: got %h, required 00", v); end
        read_addr(a);
        cpu_read(8'h08, v);
        total++; if (a !== 32'h10 || v !== 8'h02) begin bad++; $display("FAIL timeout_retain: got addr %h count %h, required 10 and 02", a, v); end
    endtask

    task automatic test_ignored_starts();
        logic [7:0] v;
        logic [31:0] a;
        int p;
        cpu_write(8'h08, 8'h00);
        p = pulses;
        cpu_write(8'h05, 8'h00);
        tick(3);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h00 || pulses !== p) begin bad++; $display("FAIL zero_count_start: got status %h pulses %0d, required 00 and 0", v, pulses - p); end
        set_addr(32'h0000_0300);
        cpu_write(8'h08, 8'h02);
        pulse_q.push_back({1'b0, 32'h0000_0300});
        cpu_write(8'h06, 8'h00);
        tick(3);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL busy_state: got %h, required 01", v); end
        cpu_write(8'h05, 8'h00);
        cpu_write(8'h06, 8'h00);
        cpu_write(8'h00, 8'hFF);
        tick(2);
        total++; if (pulses !== p + 1) begin bad++; $display("FAIL busy_start: got %0d pulses, required 1", pulses - p); end
        @(negedge clk_i);
        sd_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = 8'h0B; eng_done = 1'b1;
        @(negedge clk_i);
        sd_cs = 1'b0; R_W_n = 1'b1; eng_done = 1'b0;
        cpu_read(8'h04, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL abort_done_status: got %h, required 00", v); end
        read_addr(a);
        cpu_read(8'h08, v);
        total++; if (a !== 32'h300 || v !== 8'h02) begin bad++; $display("FAIL abort_done_regs: got addr %h count %h, required 300 and 02", a, v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        logic [31:0] a;
        cpu_write(8'h09, 8'h01);
        cpu_write(8'h07, 8'h03);
        set_addr(32'hABCD_0123);
        cpu_write(8'h08, 8'h05);
        pulse_q.push_back({1'b1, 32'hABCD_0123});
        cpu_write(8'h05, 8'h00);
        tick(3);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h09) begin bad++; $display("FAIL mid_xfer: got %h, required 09", v); end
        @(negedge clk_i);
        rst_n_i = 1'b0; eng_done = 1'b1;
        sd_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = 8'h07; data_i = 8'h01;
        @(negedge clk_i);
        eng_done = 1'b0; sd_cs = 1'b0; R_W_n = 1'b1; reg_addr_i = 8'h04;
        #1;
        total++;
        if (data_o !== 8'h00 || eng_sector !== 32'h0 || irq_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset_now: got status %h sector %h irq %b, required 00 0 0", data_o, eng_sector, irq_o);
        end
        read_addr(a);
        cpu_read(8'h08, v);
        total++; if (a !== 32'h0 || v !== 8'h00) begin bad++; $display("FAIL mid_reset_regs: got addr %h count %h, required 0 and 00", a, v); end
        cpu_read(8'h07, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_reset_page: got %h, required 00", v); end
        cpu_read(8'h09, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_reset_ctrl: got %h, required 00", v); end
        rst_n_i = 1'b1;
        tick(2);
        cpu_read(8'h04, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_reset_idle: got %h, required 00", v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0; R_W_n = 1'b1; reg_addr_i = 8'h00; data_i = 8'h00; sd_cs = 1'b0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_outen = 1'b0; eng_outaddr = 9'h000; eng_outbyte = 8'h00;
        test_reset();
        test_single_read();
        test_burst_write();
        test_window();
        test_timeout();
        test_ignored_starts();
        test_reset_mid();
        total++;
        if (pulse_q.size() != 0 || buf_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pulses %0d bytes left, required 0 and 0", pulse_q.size(), buf_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
